vending_machine_change: RTL and testbench

Parametrised successor to the fixed-price vending FSM. Accepts nickel, dime and quarter coins against a configurable price, dispenses on reaching it, and returns any overpayment or a cancelled credit as a train of one-nickel pulses. Sits between the coin-acceptor front end (one-cycle coin pulses) and the dispense/refund actuators.

---
 rtl/vending_machine_change.sv | 141 ++++++++++++++
 tb/tb_vending_machine_change.sv | 137 +++++++++++++
 2 files changed

// File: rtl/vending_machine_change.sv
// vending_machine_change
//   Coin-operated vend controller with a configurable price. Credits nickel,
//   dime and quarter pulses, dispenses once the price is reached, and returns
//   overpayment or a cancelled credit as one-nickel change pulses.
//
// Parameters
//   W          credit accumulator width (cents)
//   PRICE      item price (cents, > 0, multiple of V_NICKEL)
//   V_NICKEL   nickel value, also the change unit
//   V_DIME     dime value
//   V_QUARTER  quarter value
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   nickel       coin pulse, one cycle per coin
//   dime         coin pulse
//   quarter      coin pulse
//   cancel       refund request for the current credit
//   dispense     registered one-cycle vend pulse
//   change_out   registered pulse, one nickel returned per high cycle
//   coin_reject  registered one-cycle pulse when a coin is not credited
//   busy         high while in VEND or CHANGE
//   total        registered credit in cents
module vending_machine_change #(
    parameter int unsigned W         = 6,
    parameter int unsigned PRICE     = 15,
    parameter int unsigned V_NICKEL  = 5,
    parameter int unsigned V_DIME    = 10,
    parameter int unsigned V_QUARTER = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         nickel,
    input  logic         dime,
    input  logic         quarter,
    input  logic         cancel,
    output logic         dispense,
    output logic         change_out,
    output logic         coin_reject,
    output logic         busy,
    output logic [W-1:0] total
);

    localparam logic [W-1:0] P_PRICE = W'(PRICE);
    localparam logic [W-1:0] P_NICK  = W'(V_NICKEL);
    localparam logic [W-1:0] P_DIME  = W'(V_DIME);
    localparam logic [W-1:0] P_QUAR  = W'(V_QUARTER);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        VEND,
        CHANGE
    } state_t;

    state_t       state, state_nx;
    logic [W-1:0] total_nx;
    logic         dispense_nx;
    logic         change_nx;
    logic         reject_nx;

    logic         coin_any;
    logic         coin_multi;
    logic [W-1:0] coin_val;
    logic [W-1:0] sum;

    assign coin_any   = nickel | dime | quarter;
    assign coin_multi = (nickel & dime) | (nickel & quarter) | (dime & quarter);

    // Only the highest-value coin is credited when several arrive together.
    always_comb begin
        coin_val = '0;
        if (quarter)     coin_val = P_QUAR;
        else if (dime)   coin_val = P_DIME;
        else if (nickel) coin_val = P_NICK;
    end

    assign sum  = total + coin_val;
    assign busy = (state == VEND) || (state == CHANGE);

    always_comb begin
        state_nx    = state;
        total_nx    = total;
        dispense_nx = 1'b0;
        change_nx   = 1'b0;
        reject_nx   = 1'b0;
        unique case (state)
            IDLE, COLLECT: begin
                if (cancel && coin_any) begin
                    // Cancel beats any coin; in IDLE the cancel itself is a no-op.
                    reject_nx = 1'b1;
                    if (state == COLLECT) state_nx = CHANGE;
                end else if (cancel) begin
                    if (state == COLLECT) state_nx = CHANGE;
                end else if (coin_any) begin
                    reject_nx = coin_multi;
                    total_nx  = sum;
                    if (sum >= P_PRICE) begin
                        dispense_nx = 1'b1;
                        state_nx    = VEND;
                    end else begin
                        state_nx = COLLECT;
                    end
                end
            end
            VEND: begin
                reject_nx = coin_any;
                total_nx  = total - P_PRICE;
                state_nx  = (total_nx != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                reject_nx = coin_any;
                change_nx = 1'b1;
                total_nx  = total - P_NICK;
                if (total == P_NICK) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                total_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            total       <= '0;
            dispense    <= 1'b0;
            change_out  <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_nx;
            total       <= total_nx;
            dispense    <= dispense_nx;
            change_out  <= change_nx;
            coin_reject <= reject_nx;
        end
    end

endmodule

// File: tb/tb_vending_machine_change.sv
// tb_vending_machine_change
//   Directed bench: one instance with default parameters and one with
//   PRICE = 20; expected values are hand-computed per step.
module tb_vending_machine_change;

    logic       clk = 1'b0;
    logic       a_rst_n, a_nickel, a_dime, a_quarter, a_cancel;
    logic       a_dispense, a_change, a_reject, a_busy;
    logic [5:0] a_total;
    logic       b_rst_n, b_nickel, b_dime, b_quarter, b_cancel;
    logic       b_dispense, b_change, b_reject, b_busy;
    logic [5:0] b_total;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vending_machine_change u_a (
        .clk(clk), .rst_n(a_rst_n), .nickel(a_nickel), .dime(a_dime),
        .quarter(a_quarter), .cancel(a_cancel), .dispense(a_dispense),
        .change_out(a_change), .coin_reject(a_reject), .busy(a_busy),
        .total(a_total)
    );

    vending_machine_change #(.W(6), .PRICE(20)) u_b (
        .clk(clk), .rst_n(b_rst_n), .nickel(b_nickel), .dime(b_dime),
        .quarter(b_quarter), .cancel(b_cancel), .dispense(b_dispense),
        .change_out(b_change), .coin_reject(b_reject), .busy(b_busy),
        .total(b_total)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Check all default-instance outputs at once.
    task automatic chk_a(input string tag, input int tot, input int disp,
                         input int chg, input int rej, input int bsy);
        chk({tag, ".total"},  int'(a_total), tot);
        chk({tag, ".disp"},   int'(a_dispense), disp);
        chk({tag, ".change"}, int'(a_change), chg);
        chk({tag, ".reject"}, int'(a_reject), rej);
        chk({tag, ".busy"},   int'(a_busy), bsy);
    endtask

    // One clock edge, then clear the coin/cancel inputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        a_nickel = 0; a_dime = 0; a_quarter = 0; a_cancel = 0;
        b_nickel = 0; b_dime = 0; b_quarter = 0; b_cancel = 0;
    endtask

    initial begin
        a_rst_n = 0; a_nickel = 0; a_dime = 0; a_quarter = 0; a_cancel = 0;
        b_rst_n = 0; b_nickel = 0; b_dime = 0; b_quarter = 0; b_cancel = 0;
        step();
        step();
        chk_a("reset", 0, 0, 0, 0, 0);
        chk("reset_b.total", int'(b_total), 0);
        a_rst_n = 1; b_rst_n = 1;
        step();

        // Three nickels
        a_nickel = 1; step(); chk_a("n1", 5, 0, 0, 0, 0);
        a_nickel = 1; step(); chk_a("n2", 10, 0, 0, 0, 0);
        a_nickel = 1; step(); chk_a("n3", 15, 1, 0, 0, 1);
        step();               chk_a("n_vend", 0, 0, 0, 0, 0);
        step();               chk_a("n_idle", 0, 0, 0, 0, 0);

        // One quarter: 10 cents change
        a_quarter = 1; step(); chk_a("q1", 25, 1, 0, 0, 1);
        step();                chk_a("q_vend", 10, 0, 0, 0, 1);
        step();                chk_a("q_ch1", 5, 0, 1, 0, 1);
        step();                chk_a("q_ch2", 0, 0, 1, 0, 0);
        step();                chk_a("q_done", 0, 0, 0, 0, 0);

        // Cancel in IDLE is ignored
        a_cancel = 1; step(); chk_a("idle_cancel", 0, 0, 0, 0, 0);

        // Dime, then cancel
        a_dime = 1;   step(); chk_a("d1", 10, 0, 0, 0, 0);
        a_cancel = 1; step(); chk_a("d_cancel", 10, 0, 0, 0, 1);
        step();               chk_a("d_ch1", 5, 0, 1, 0, 1);
        step();               chk_a("d_ch2", 0, 0, 1, 0, 0);
        step();               chk_a("d_done", 0, 0, 0, 0, 0);

        // Quarter, nickel inserted during the change train
        a_quarter = 1; step(); chk_a("qc1", 25, 1, 0, 0, 1);
        step();                chk_a("qc_vend", 10, 0, 0, 0, 1);
        a_nickel = 1;  step(); chk_a("qc_ch1", 5, 0, 1, 1, 1);
        step();                chk_a("qc_ch2", 0, 0, 1, 0, 0);
        step();                chk_a("qc_done", 0, 0, 0, 0, 0);

        // Simultaneous dime+nickel in IDLE, then cancel+quarter in COLLECT
        a_dime = 1; a_nickel = 1;     step(); chk_a("sim_dn", 10, 0, 0, 1, 0);
        a_cancel = 1; a_quarter = 1;  step(); chk_a("sim_cq", 10, 0, 0, 1, 1);
        step();                              chk_a("sim_ch1", 5, 0, 1, 0, 1);
        step();                              chk_a("sim_ch2", 0, 0, 1, 0, 0);
        step();                              chk_a("sim_done", 0, 0, 0, 0, 0);

        // PRICE = 20: dime then quarter, reset during change
        b_dime = 1;    step();
        chk("b_d.total", int'(b_total), 10);
        chk("b_d.disp", int'(b_dispense), 0);
        b_quarter = 1; step();
        chk("b_q.total", int'(b_total), 35);
        chk("b_q.disp", int'(b_dispense), 1);
        step();
        chk("b_vend.total", int'(b_total), 15);
        chk("b_vend.busy", int'(b_busy), 1);
        step();
        chk("b_ch1.total", int'(b_total), 10);
        chk("b_ch1.change", int'(b_change), 1);
        #2 b_rst_n = 0;
        #1;
        chk("b_rst.total", int'(b_total), 0);
        chk("b_rst.change", int'(b_change), 0);
        chk("b_rst.busy", int'(b_busy), 0);
        chk("b_rst.disp", int'(b_dispense), 0);
        step();
        chk("b_rst_hold.change", int'(b_change), 0);
        b_rst_n = 1;
        step();
        chk("b_after.total", int'(b_total), 0);
        chk("b_after.change", int'(b_change), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
